led_toggle_bank: RTL and testbench
==================================

// Module: led_toggle_bank
// PURPOSE
//   Multi-channel successor to the single-button toggle flip-flop: CHANNELS raw button inputs,
//   each synchronised, counter-debounced and edge-detected, driving one LED output per channel.
//   Per-channel runtime mode: toggle, follow, pulse-stretch or forced off. Runs in the divided
//   clock domain (clk_out from clk_div), between the board buttons and the LED pins.
// PARAMETERS
//   CHANNELS     4   number of independent button/LED channels (1..8)
//   DB_CYCLES    4   consecutive clk_out edges of changed input needed to accept a new level (2..255)
//   PULSE_CYCLES 8   LED high time, in clk_out cycles, for pulse-stretch mode (1..255)
// PORTS
//   clk_out  in   1            divided clock; all state changes on its rising edge
//   rst      in   1            asynchronous, active-high reset
//   d        in   CHANNELS     raw button levels, asynchronous to clk_out, 1 = pressed
//   mode     in   2*CHANNELS   per-channel mode, bits [2i+1:2i] for channel i; sampled every edge
//   led      out  CHANNELS     registered LED drive, 1 = on
//   press    out  CHANNELS     registered one-cycle pulse per accepted debounced rising edge
// BEHAVIOUR
//   Reset (async, any time): sync FFs, stable levels, debounce counters, toggle state,
//     pulse counters, led and press all clear to 0. Deassertion is taken on the next clk_out edge.
//   Per channel i (channels fully independent, identical logic):
//   - Sync: 2-FF chain d[i] -> s1 -> s2. Only s2 is used downstream.
//   - Debounce: state stable, counter dbc (width ceil(log2(DB_CYCLES+1))).
//     s2 == stable : dbc <= 0.
//     s2 != stable : dbc <= dbc+1; on the edge where dbc+1 == DB_CYCLES, stable <= s2, dbc <= 0.
//     A glitch shorter than DB_CYCLES edges restarts dbc and never changes stable.
//   - Event: rise = (stable 0->1 on this edge). press[i] is registered; it is high for exactly
//     one cycle, on the edge after stable rises. Release (1->0) generates no event.
//   - Toggle state tq: flips on the same edge stable rises; updated in every mode.
//   - Pulse counter pc (8 bit): on rise, pc <= PULSE_CYCLES (retrigger reloads, never adds);
//     otherwise it decrements while nonzero, saturating at 0. Runs in every mode.
//   - mode 00 toggle : led <= tq
//     mode 01 follow : led <= stable
//     mode 10 pulse  : led <= (pc != 0)
//     mode 11 off    : led <= 0
//     led is registered: it shows the next-state values one edge after the internal update.
//   - Latency, d held high from before edge E0: s2=1 after E1, stable=1 and tq flips after E(DB+1),
//     led and press change after E(DB+2); i.e. DB_CYCLES+3 edges from E0.
//   - Pulse mode: led is high for exactly PULSE_CYCLES cycles after a single press.
//   - A mode change takes effect on the next edge; tq and pc are preserved, no glitch beyond one led update.
//   - Holding the button produces one event only; a new event requires a debounced release first.
//   - Reset mid-debounce or mid-pulse aborts that operation; after reset an already-held button
//     counts as a fresh press once debounced (stable restarts from 0).
// TESTING (CHANNELS=4, DB_CYCLES=4, PULSE_CYCLES=8)
//   1 rst=1 then 0, d=0 -> led=0, press=0 for 20 cycles; assert rst mid-run -> all outputs 0 immediately.
//   2 mode=00, d[0] high 10 cycles then low 10 -> press[0] 1 cycle on edge 6, led[0] 0->1 at edge 6, stays 1;
//     second press -> led[0]=0.
//   3 d[1] bounce 1,0,1,0 (1-cycle glitches) then steady 1; mode=01 -> no press during bounce,
//     led[1]=1 7 edges after steady start.
//   4 mode=10 on ch2, one press -> led[2] high exactly 8 cycles; re-press at pulse cycle 5 -> reload, high 8 more.
//   5 all 4 channels pressed on the same edge, modes 00/01/10/11 -> press=4'b1111 for one cycle,
//     led=4'b0111 on that edge.
//   6 ch0 toggled on (mode 00), switch to 11 then back to 00 -> led 0 while off, returns to 1, no press.

Source files
------------

// File: rtl/led_toggle_bank.sv
// led_toggle_bank
// Bank of independent button-to-LED channels running in the divided clock
// domain. Each channel synchronises its raw button, debounces it with a
// consecutive-sample counter, detects accepted rising edges and drives its
// LED in one of four runtime modes: toggle, follow, pulse-stretch or off.
// All channel state clears asynchronously on rst.

module led_toggle_bank #(
  parameter int CHANNELS     = 4,
  parameter int DB_CYCLES    = 4,
  parameter int PULSE_CYCLES = 8
) (
  input  logic                  clk_out,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   d,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   led,
  output logic [CHANNELS-1:0]   press
);

  // Debounce counter wide enough to hold DB_CYCLES.
  localparam int DBW = $clog2(DB_CYCLES + 1);

  // Counter value at which the next mismatching sample completes the debounce.
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ZERO    = DBW'(0);
  localparam logic [DBW-1:0] DB_ONE     = DBW'(1);
  localparam logic [7:0]     PULSE_LOAD = 8'(PULSE_CYCLES);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_FOLLOW = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    // Registered channel state.
    logic           s1_r;
    logic           s2_r;
    logic           stable_r;
    logic [DBW-1:0] dbc_r;
    logic           tq_r;
    logic [7:0]     pc_r;
    logic           rise_r;
    logic           led_r;
    logic           press_r;

    // Next-state values.
    logic           stable_nxt_s;
    logic [DBW-1:0] dbc_nxt_s;
    logic           rise_s;
    logic [7:0]     pc_nxt_s;
    logic           led_nxt_s;
    logic [1:0]     mode_s;

    assign mode_s = mode[2*i +: 2];

    // Debounce: count consecutive samples that differ from the accepted level.
    always_comb begin
      stable_nxt_s = stable_r;
      dbc_nxt_s    = DB_ZERO;
      if (s2_r == stable_r) begin
        stable_nxt_s = stable_r;
        dbc_nxt_s    = DB_ZERO;
      end else if (dbc_r == DB_LAST) begin
        stable_nxt_s = s2_r;
        dbc_nxt_s    = DB_ZERO;
      end else begin
        stable_nxt_s = stable_r;
        dbc_nxt_s    = dbc_r + DB_ONE;
      end
    end

    // Rising-edge detect on the accepted level and pulse-stretch counter.
    always_comb begin
      rise_s   = stable_nxt_s & ~stable_r;
      pc_nxt_s = 8'd0;
      if (rise_s) begin
        pc_nxt_s = PULSE_LOAD;
      end else if (pc_r != 8'd0) begin
        pc_nxt_s = pc_r - 8'd1;
      end else begin
        pc_nxt_s = 8'd0;
      end
    end

    // LED source select from the current registered channel state.
    always_comb begin
      led_nxt_s = 1'b0;
      case (mode_s)
        MODE_TOGGLE: led_nxt_s = tq_r;
        MODE_FOLLOW: led_nxt_s = stable_r;
        MODE_PULSE:  led_nxt_s = (pc_r != 8'd0);
        MODE_OFF:    led_nxt_s = 1'b0;
        default:     led_nxt_s = 1'b0;
      endcase
    end

    // Channel state registers; press follows the internal rise by one edge.
    always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
        s1_r     <= 1'b0;
        s2_r     <= 1'b0;
        stable_r <= 1'b0;
        dbc_r    <= DB_ZERO;
        tq_r     <= 1'b0;
        pc_r     <= 8'd0;
        rise_r   <= 1'b0;
        led_r    <= 1'b0;
        press_r  <= 1'b0;
      end else begin
        s1_r     <= d[i];
        s2_r     <= s1_r;
        stable_r <= stable_nxt_s;
        dbc_r    <= dbc_nxt_s;
        tq_r     <= tq_r ^ rise_s;
        pc_r     <= pc_nxt_s;
        rise_r   <= rise_s;
        led_r    <= led_nxt_s;
        press_r  <= rise_r;
      end
    end

    assign led[i]   = led_r;
    assign press[i] = press_r;

  end : g_ch

endmodule

// File: tb/tb_led_toggle_bank.sv
// tb_led_toggle_bank
// Directed bench for led_toggle_bank with CHANNELS=4, DB_CYCLES=4,
// PULSE_CYCLES=8. Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, so every check sees settled registers.

module tb_led_toggle_bank;

  logic       clk_out;
  logic       rst;
  logic [3:0] d;
  logic [7:0] mode;
  logic [3:0] led;
  logic [3:0] press;

  int total;
  int bad;

  led_toggle_bank #(
    .CHANNELS     (4),
    .DB_CYCLES    (4),
    .PULSE_CYCLES (8)
  ) dut (
    .clk_out (clk_out),
    .rst     (rst),
    .d       (d),
    .mode    (mode),
    .led     (led),
    .press   (press)
  );

  // Free-running divided clock.
  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_out);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence.
  initial begin
    logic exp_led2;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    d     = 4'b0000;
    mode  = 8'b00_00_00_00;

    // 1: reset values, idle run, async reset mid-operation.
    tick(2);
    check("rst_led", {28'd0, led}, 32'h0);
    check("rst_press", {28'd0, press}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("idle_led", {28'd0, led}, 32'h0);
      check("idle_press", {28'd0, press}, 32'h0);
    end
    d[0] = 1'b1;
    tick(7);
    check("pre_rst_led", {28'd0, led}, 32'h1);
    check("pre_rst_press", {28'd0, press}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", {28'd0, led}, 32'h0);
    check("async_rst_press", {28'd0, press}, 32'h0);
    tick(1);
    check("held_rst_led", {28'd0, led}, 32'h0);
    rst = 1'b0;
    tick(6);
    check("post_rst_early_press", {28'd0, press}, 32'h0);
    tick(1);
    check("post_rst_fresh_press", {28'd0, press}, 32'h1);
    check("post_rst_fresh_led", {28'd0, led}, 32'h1);
    d   = 4'b0000;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);

    // 2: toggle mode on channel 0.
    d[0] = 1'b1;
    tick(6);
    check("t2_press_early", {28'd0, press}, 32'h0);
    check("t2_led_early", {31'd0, led[0]}, 32'h0);
    tick(1);
    check("t2_press", {28'd0, press}, 32'h1);
    check("t2_led_on", {31'd0, led[0]}, 32'h1);
    tick(1);
    check("t2_press_one_cycle", {28'd0, press}, 32'h0);
    tick(2);
    check("t2_hold_no_repeat", {28'd0, press}, 32'h0);
    d[0] = 1'b0;
    tick(10);
    check("t2_led_stays", {31'd0, led[0]}, 32'h1);
    check("t2_release_no_press", {28'd0, press}, 32'h0);
    d[0] = 1'b1;
    tick(7);
    check("t2_press2", {28'd0, press}, 32'h1);
    check("t2_led_off", {31'd0, led[0]}, 32'h0);
    d[0] = 1'b0;
    tick(12);

    // 3: bounce on channel 1 in follow mode.
    mode = 8'b00_00_01_00;
    for (int k = 0; k < 4; k++) begin
      d[1] = (k % 2 == 0);
      tick(1);
      check("t3_bounce_press", {28'd0, press}, 32'h0);
    end
    d[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("t3_settle_press", {28'd0, press}, 32'h0);
      check("t3_settle_led", {31'd0, led[1]}, 32'h0);
    end
    tick(1);
    check("t3_press", {28'd0, press}, 32'h2);
    check("t3_led_follow", {31'd0, led[1]}, 32'h1);
    d[1] = 1'b0;
    tick(10);
    check("t3_led_release", {31'd0, led[1]}, 32'h0);

    // 4: pulse mode on channel 2, then a second press mid-pulse.
    mode = 8'b00_10_01_00;
    d[2] = 1'b1;
    tick(7);
    check("t4_press", {31'd0, press[2]}, 32'h1);
    check("t4_led_e6", {31'd0, led[2]}, 32'h1);
    d[2] = 1'b0;
    for (int e = 7; e <= 10; e++) begin
      tick(1);
      check("t4_led_hold", {31'd0, led[2]}, 32'h1);
    end
    d[2] = 1'b1;
    for (int e = 11; e <= 25; e++) begin
      tick(1);
      exp_led2 = (e <= 13) || ((e >= 17) && (e <= 24));
      check("t4_led_pulse", {31'd0, led[2]}, {31'd0, exp_led2});
      if (e == 17) begin
        check("t4_press2", {31'd0, press[2]}, 32'h1);
      end else begin
        check("t4_no_press", {31'd0, press[2]}, 32'h0);
      end
    end
    d[2] = 1'b0;
    tick(12);

    // 5: all channels pressed together, one mode each.
    mode = 8'b11_10_01_00;
    d    = 4'b1111;
    tick(6);
    check("t5_press_early", {28'd0, press}, 32'h0);
    tick(1);
    check("t5_press_all", {28'd0, press}, 32'hF);
    check("t5_led_modes", {28'd0, led}, 32'h7);
    tick(1);
    check("t5_press_clear", {28'd0, press}, 32'h0);

    // 6: channel 0 switched off and back on without an event.
    d = 4'b0000;
    tick(12);
    check("t6_led_before", {28'd0, led}, 32'h1);
    mode[1:0] = 2'b11;
    tick(1);
    check("t6_led_off", {28'd0, led}, 32'h0);
    tick(3);
    check("t6_led_still_off", {28'd0, led}, 32'h0);
    check("t6_off_press", {28'd0, press}, 32'h0);
    mode[1:0] = 2'b00;
    tick(1);
    check("t6_led_back", {28'd0, led}, 32'h1);
    check("t6_back_press", {28'd0, press}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
